// File: rtl/mem_bus_arbiter.sv
// Two-requester (icache/dcache) arbiter for the single memory port, with a
// per-tag ownership table that steers returned load data to its requester.
module mem_bus_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int NUM_TAGS     = 16
) (
  input  logic        clock,
  input  logic        reset,

  input  logic [1:0]  icache2arb_command,
  input  logic [63:0] icache2arb_addr,
  output logic [3:0]  arb2icache_response,
  output logic [3:0]  arb2icache_tag,
  output logic [63:0] arb2icache_data,

  input  logic [1:0]  dcache2arb_command,
  input  logic [63:0] dcache2arb_addr,
  input  logic [63:0] dcache2arb_data,
  output logic [3:0]  arb2dcache_response,
  output logic [3:0]  arb2dcache_tag,
  output logic [63:0] arb2dcache_data,

  output logic [1:0]  proc2mem_command,
  output logic [63:0] proc2mem_addr,
  output logic [63:0] proc2mem_data,

  input  logic [3:0]  mem2proc_response,
  input  logic [3:0]  mem2proc_tag,
  input  logic [63:0] mem2proc_data,

  output logic        grant_icache,
  output logic        stray_tag
);

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } bus_cmd_e;

  localparam logic [3:0] LIMIT    = 4'(STARVE_LIMIT);
  localparam logic       OWNER_IC = 1'b0;
  localparam logic       OWNER_DC = 1'b1;

  logic [3:0]          starve_cnt_q, starve_cnt_d;
  logic [NUM_TAGS-1:0] valid_q, valid_d;
  logic [NUM_TAGS-1:0] owner_q, owner_d;

  logic ic_req, dc_req, grant_ic, grant_dc, load_fwd;
  logic ret_in_range, resp_in_range, ret_entry_valid, ret_entry_owner, ret_hit;

  // Arbitration. Outputs are gated by reset so that asserting it drops every
  // state-derived output at once, without waiting for a clock edge.
  always_comb begin
    ic_req   = (icache2arb_command == BUS_LOAD);
    dc_req   = (dcache2arb_command == BUS_LOAD) || (dcache2arb_command == BUS_STORE);
    grant_ic = reset && ic_req && (!dc_req || (starve_cnt_q == LIMIT));
    grant_dc = reset && dc_req && !grant_ic;
    load_fwd = grant_ic || (grant_dc && (dcache2arb_command == BUS_LOAD));
  end

  always_comb begin
    ret_in_range    = (32'(mem2proc_tag) < NUM_TAGS);
    resp_in_range   = (32'(mem2proc_response) < NUM_TAGS);
    ret_entry_valid = ret_in_range ? valid_q[mem2proc_tag] : 1'b0;
    ret_entry_owner = ret_in_range ? owner_q[mem2proc_tag] : OWNER_IC;
    ret_hit         = reset && (mem2proc_tag != 4'd0) && ret_entry_valid;
  end

  always_comb begin
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = 64'd0;
    proc2mem_data    = 64'd0;
    if (grant_ic) begin
      proc2mem_command = BUS_LOAD;
      proc2mem_addr    = icache2arb_addr;
    end else if (grant_dc) begin
      proc2mem_command = dcache2arb_command;
      proc2mem_addr    = dcache2arb_addr;
      proc2mem_data    = dcache2arb_data;
    end

    arb2icache_response = grant_ic ? mem2proc_response : 4'd0;
    arb2dcache_response = grant_dc ? mem2proc_response : 4'd0;
    arb2icache_tag      = (ret_hit && ret_entry_owner == OWNER_IC) ? mem2proc_tag : 4'd0;
    arb2dcache_tag      = (ret_hit && ret_entry_owner == OWNER_DC) ? mem2proc_tag : 4'd0;
    arb2icache_data     = mem2proc_data;
    arb2dcache_data     = mem2proc_data;
    grant_icache        = grant_ic;
    stray_tag           = reset && (mem2proc_tag != 4'd0) && !ret_entry_valid;
  end

  always_comb begin
    valid_d      = valid_q;
    owner_d      = owner_q;
    starve_cnt_d = 4'd0;

    // NOTE: blocking assignments in always_comb run in order, so placing the
    // set after the clear makes a same-cycle reuse of a returning tag win.
    if (ret_hit) begin
      valid_d[mem2proc_tag] = 1'b0;
    end
    if (load_fwd && (mem2proc_response != 4'd0) && resp_in_range) begin
      valid_d[mem2proc_response] = 1'b1;
      owner_d[mem2proc_response] = grant_dc ? OWNER_DC : OWNER_IC;
    end

    if (ic_req && !grant_ic) begin
      starve_cnt_d = (starve_cnt_q == LIMIT) ? starve_cnt_q : starve_cnt_q + 4'd1;
    end
  end

  // NOTE: the tag table must be reset, because loads in flight across reset
  // have to be seen as strays rather than routed by stale valid bits.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_cnt_q <= 4'd0;
      valid_q      <= '0;
      owner_q      <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      valid_q      <= valid_d;
      owner_q      <= owner_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter: arbitration, starvation,
// tag ownership routing, tag reuse and asynchronous reset.
module tb_mem_bus_arbiter;

  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;
  localparam logic [63:0] MEM_DATA = 64'hCAFE_F00D_1234_5678;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  icache2arb_command;
  logic [63:0] icache2arb_addr;
  logic [3:0]  arb2icache_response, arb2icache_tag;
  logic [63:0] arb2icache_data;
  logic [1:0]  dcache2arb_command;
  logic [63:0] dcache2arb_addr, dcache2arb_data;
  logic [3:0]  arb2dcache_response, arb2dcache_tag;
  logic [63:0] arb2dcache_data;
  logic [1:0]  proc2mem_command;
  logic [63:0] proc2mem_addr, proc2mem_data;
  logic [3:0]  mem2proc_response, mem2proc_tag;
  logic [63:0] mem2proc_data;
  logic        grant_icache, stray_tag;

  int checks = 0;
  int errors = 0;

  mem_bus_arbiter #(.STARVE_LIMIT(4), .NUM_TAGS(16)) dut (
    .clock               (clock),
    .reset               (reset),
    .icache2arb_command  (icache2arb_command),
    .icache2arb_addr     (icache2arb_addr),
    .arb2icache_response (arb2icache_response),
    .arb2icache_tag      (arb2icache_tag),
    .arb2icache_data     (arb2icache_data),
    .dcache2arb_command  (dcache2arb_command),
    .dcache2arb_addr     (dcache2arb_addr),
    .dcache2arb_data     (dcache2arb_data),
    .arb2dcache_response (arb2dcache_response),
    .arb2dcache_tag      (arb2dcache_tag),
    .arb2dcache_data     (arb2dcache_data),
    .proc2mem_command    (proc2mem_command),
    .proc2mem_addr       (proc2mem_addr),
    .proc2mem_data       (proc2mem_data),
    .mem2proc_response   (mem2proc_response),
    .mem2proc_tag        (mem2proc_tag),
    .mem2proc_data       (mem2proc_data),
    .grant_icache        (grant_icache),
    .stray_tag           (stray_tag)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    icache2arb_command = BUS_NONE;
    icache2arb_addr    = 64'd0;
    dcache2arb_command = BUS_NONE;
    dcache2arb_addr    = 64'd0;
    dcache2arb_data    = 64'd0;
    mem2proc_response  = 4'd0;
    mem2proc_tag       = 4'd0;
  endtask

  // Advance to just after the next rising edge, where new inputs are applied.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Outputs are sampled on the falling edge, well away from the active edge.
  task automatic settle();
    @(negedge clock);
  endtask

  task automatic expect_return(input string name, input logic [3:0] tag,
                               input logic [3:0] exp_i, input logic [3:0] exp_d,
                               input logic exp_stray);
    idle();
    mem2proc_tag = tag;
    settle();
    check({name, "_itag"},  arb2icache_tag, exp_i);
    check({name, "_dtag"},  arb2dcache_tag, exp_d);
    check({name, "_stray"}, stray_tag,      exp_stray);
    tick();
  endtask

  logic [9:0] grant_pattern;

  initial begin
    mem2proc_data = MEM_DATA;
    idle();

    // Reset state, with live stimulus that must be masked.
    reset              = 1'b0;
    icache2arb_command = BUS_LOAD;
    icache2arb_addr    = 64'h55;
    mem2proc_response  = 4'd3;
    mem2proc_tag       = 4'd7;
    settle();
    check("rst_cmd",   proc2mem_command,    BUS_NONE);
    check("rst_addr",  proc2mem_addr,       64'd0);
    check("rst_grant", grant_icache,        1'b0);
    check("rst_iresp", arb2icache_response, 4'd0);
    check("rst_stray", stray_tag,           1'b0);
    check("rst_idata", arb2icache_data,     MEM_DATA);
    tick();
    reset = 1'b1;
    idle();
    tick();

    // 1: icache alone.
    icache2arb_command = BUS_LOAD;
    icache2arb_addr    = 64'h1000;
    mem2proc_response  = 4'd3;
    settle();
    check("t1_cmd",   proc2mem_command,    BUS_LOAD);
    check("t1_addr",  proc2mem_addr,       64'h1000);
    check("t1_iresp", arb2icache_response, 4'd3);
    check("t1_dresp", arb2dcache_response, 4'd0);
    check("t1_grant", grant_icache,        1'b1);
    tick();
    idle();
    for (int i = 0; i < 4; i++) tick();
    expect_return("t1_ret",   4'd3, 4'd3, 4'd0, 1'b0);
    expect_return("t1_again", 4'd3, 4'd0, 4'd0, 1'b1);

    // 2: contention, memory always accepts with tag 1.
    grant_pattern = 10'b1000010000;  // bit i = expected grant_icache in cycle i
    for (int i = 0; i < 10; i++) begin
      icache2arb_command = BUS_LOAD;
      icache2arb_addr    = 64'hA000;
      dcache2arb_command = BUS_LOAD;
      dcache2arb_addr    = 64'hB000;
      mem2proc_response  = 4'd1;
      settle();
      check($sformatf("t2_grant%0d", i), grant_icache, grant_pattern[i]);
      if (i == 0) begin
        check("t2_addr",  proc2mem_addr,       64'hB000);
        check("t2_dresp", arb2dcache_response, 4'd1);
        check("t2_iresp", arb2icache_response, 4'd0);
      end
      tick();
    end
    // Tag 1 was last taken by the icache grant in cycle 9.
    expect_return("t2_ret", 4'd1, 4'd1, 4'd0, 1'b0);

    // 3: dcache store beats a pending icache load.
    icache2arb_command = BUS_LOAD;
    icache2arb_addr    = 64'h3000;
    dcache2arb_command = BUS_STORE;
    dcache2arb_addr    = 64'h2000;
    dcache2arb_data    = 64'hDEAD;
    mem2proc_response  = 4'd6;
    settle();
    check("t3_cmd",   proc2mem_command,    BUS_STORE);
    check("t3_data",  proc2mem_data,       64'hDEAD);
    check("t3_iresp", arb2icache_response, 4'd0);
    check("t3_dresp", arb2dcache_response, 4'd6);
    tick();
    idle();
    tick();
    expect_return("t3_ret", 4'd6, 4'd0, 4'd0, 1'b1);

    // 4: memory rejects dcache loads; icache still counts its losses.
    for (int i = 0; i < 5; i++) begin
      icache2arb_command = BUS_LOAD;
      icache2arb_addr    = 64'h5000;
      dcache2arb_command = BUS_LOAD;
      dcache2arb_addr    = 64'h4000;
      mem2proc_response  = 4'd0;
      settle();
      check($sformatf("t4_grant%0d", i), grant_icache, (i == 4) ? 1'b1 : 1'b0);
      if (i == 0) check("t4_dresp", arb2dcache_response, 4'd0);
      tick();
    end
    idle();
    tick();

    // 5: tag 5 returns to icache in the same cycle dcache is given tag 5.
    icache2arb_command = BUS_LOAD;
    icache2arb_addr    = 64'h6000;
    mem2proc_response  = 4'd5;
    settle();
    check("t5_iresp", arb2icache_response, 4'd5);
    tick();
    idle();
    tick();
    dcache2arb_command = BUS_LOAD;
    dcache2arb_addr    = 64'h7000;
    mem2proc_response  = 4'd5;
    mem2proc_tag       = 4'd5;
    settle();
    check("t5_dresp", arb2dcache_response, 4'd5);
    check("t5_itag",  arb2icache_tag,      4'd5);
    check("t5_dtag",  arb2dcache_tag,      4'd0);
    check("t5_stray", stray_tag,           1'b0);
    tick();
    expect_return("t5_reuse", 4'd5, 4'd0, 4'd5, 1'b0);
    expect_return("t5_gone",  4'd5, 4'd0, 4'd0, 1'b1);

    // 6: reset asserted between edges with tags 7 (icache) and 8 (dcache) out.
    idle();
    icache2arb_command = BUS_LOAD;
    mem2proc_response  = 4'd7;
    tick();
    idle();
    dcache2arb_command = BUS_LOAD;
    mem2proc_response  = 4'd8;
    tick();
    idle();
    icache2arb_command = BUS_LOAD;
    icache2arb_addr    = 64'h9000;
    mem2proc_response  = 4'd9;
    mem2proc_tag       = 4'd7;
    #2;
    check("t6_pre_grant", grant_icache,   1'b1);
    check("t6_pre_itag",  arb2icache_tag, 4'd7);
    #1;
    reset = 1'b0;
    #1;
    check("t6_rst_grant", grant_icache,        1'b0);
    check("t6_rst_cmd",   proc2mem_command,    BUS_NONE);
    check("t6_rst_addr",  proc2mem_addr,       64'd0);
    check("t6_rst_iresp", arb2icache_response, 4'd0);
    check("t6_rst_itag",  arb2icache_tag,      4'd0);
    check("t6_rst_stray", stray_tag,           1'b0);
    check("t6_rst_ddata", arb2dcache_data,     MEM_DATA);
    tick();
    tick();
    idle();
    reset = 1'b1;
    tick();
    expect_return("t6_ret7", 4'd7, 4'd0, 4'd0, 1'b1);
    expect_return("t6_ret8", 4'd8, 4'd0, 4'd0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-requester arbiter for the single processor-to-memory port. It sits between `icache`/`dcache` and main memory and forwards at most one bus command per cycle. It routes the memory's accept response back to the winning requester only. It also records which requester owns each outstanding load tag, so each returned tag/data beat is delivered only to its owner.

## Interface
Parameters:
- `STARVE_LIMIT`, default 4: consecutive icache arbitration losses that force one icache-priority grant; legal range 1..15.
- `NUM_TAGS`, default 16: memory tag space. Tag 0 means "no tag / rejected".

Ports:
- `clock` in 1: single clock; all state updates on posedge.
- `reset` in 1: asynchronous, active-low; clears all state immediately while low.
- `icache2arb_command` in 2: BUS_NONE / BUS_LOAD. BUS_STORE from icache is treated as BUS_NONE.
- `icache2arb_addr` in 64: icache request address.
- `arb2icache_response` out 4: memory accept tag if the icache request was forwarded, else 0.
- `arb2icache_tag` out 4: returned tag, nonzero only if icache owns it.
- `arb2icache_data` out 64: `mem2proc_data`, passed through unconditionally.
- `dcache2arb_command` in 2: BUS_NONE / BUS_LOAD / BUS_STORE.
- `dcache2arb_addr` in 64, `dcache2arb_data` in 64: dcache request address and store data.
- `arb2dcache_response` out 4, `arb2dcache_tag` out 4, `arb2dcache_data` out 64: same rules as the icache side.
- `proc2mem_command` out 2, `proc2mem_addr` out 64, `proc2mem_data` out 64: forwarded request.
- `mem2proc_response` in 4, `mem2proc_tag` in 4, `mem2proc_data` in 64: memory response and return path.
- `grant_icache` out 1: high when the icache request is forwarded this cycle (debug/perf).
- `stray_tag` out 1: pulse when a nonzero `mem2proc_tag` has no owner.

## Operation
**Arbitration** (combinational, every cycle):
- dcache has priority by default.
- icache wins if it requests and either dcache is idle or `starve_cnt == STARVE_LIMIT`.
- The winner's command, address and data are driven to memory.
- With no request, the arbiter drives BUS_NONE, addr 0 and data 0.
- The loser sees response 0 and must retry. The existing cache retry behaviour covers this.

**Starvation counter** `starve_cnt` (4 bits, saturates at `STARVE_LIMIT`):
- Increments when icache requests and loses.
- Clears when icache is granted or icache is not requesting.

**Ownership table**: `NUM_TAGS` entries of {valid, owner}, where owner 0 = icache and 1 = dcache.
- On posedge, if a load is forwarded and `mem2proc_response != 0`, set entry[response] = {1, winner}.
- Stores are never entered, since they produce no data return.

**Return routing**:
- If `mem2proc_tag != 0`, the entry is valid and owner = X, then `arb2X_tag = mem2proc_tag`, the other side's tag = 0, and the entry clears on posedge.
- If the entry is invalid, both tags are 0 and `stray_tag` = 1.

**Simultaneous set and clear of the same tag** (memory reuses a tag in the cycle it returns it): the set wins. The entry ends valid with the new owner, and the return is still routed to the old owner.

**Reset**:
- Table cleared and `starve_cnt` = 0.
- Loads in flight across reset become strays.

## Timing
- Request path is zero latency (combinational): request to `proc2mem_*` to response in the same cycle.
- Tag return routing is zero latency; table update is visible the next cycle.
- A tag accepted in cycle N can be routed from cycle N+1 onward.
- Reset values of outputs: all commands BUS_NONE; all responses, tags and addresses 0; `grant_icache` = 0; `stray_tag` = 0.
- Data outputs follow `mem2proc_data` even while in reset.
- Reset is asynchronous: outputs derived from state go to their reset values without waiting for a clock edge.

## Test plan
1. **Icache alone:** icache LOAD 0x1000, memory response 3, tag 3 returned 5 cycles later.
   - Expect `proc2mem_addr` = 0x1000 and `arb2icache_response` = 3.
   - On return, `arb2icache_tag` = 3, `arb2dcache_tag` = 0, and entry 3 is invalid afterwards.
2. **Contention:** both request continuously, memory always accepts, `STARVE_LIMIT` = 4.
   - Expect a dcache grant for 4 cycles, an icache grant on the 5th, then the pattern repeats.
   - `grant_icache` pattern: 00001 00001.
3. **Dcache store with icache load pending:** dcache STORE with data 0xDEAD.
   - Expect `proc2mem_data` = 0xDEAD, icache response 0, and no table entry created.
   - A later `mem2proc_tag` equal to the store's response produces `stray_tag` = 1.
4. **Memory rejects** (response 0) the forwarded dcache load: no table entry is created and `starve_cnt` still increments for the waiting icache.
5. **Tag reuse:** icache tag 5 returns in the same cycle as dcache load accepted with response 5.
   - Expect `arb2icache_tag` = 5 that cycle.
   - A return of tag 5 later goes to dcache.
6. **Reset mid-flight:** assert `reset` low asynchronously between clock edges with two loads outstanding.
   - Outputs reach reset values immediately.
   - After release, both returning tags give `arb2*_tag` = 0 and `stray_tag` = 1.
